// File: rtl/lh_pkg.sv
// Shared framing constants, payload byte bounds and feeder state encoding.
// The hash core imports the same HEAD_BYTE/TAIL_BYTE so both ends agree on framing.
package lh_pkg;

   localparam logic [7:0] HEAD_BYTE    = 8'hFF;
   localparam logic [7:0] TAIL_BYTE    = 8'h00;

   // Legal payload bytes: printable ASCII and the upper range minus 0xA0/0xFF.
   localparam logic [7:0] PAYLOAD_LO_A = 8'h20;
   localparam logic [7:0] PAYLOAD_HI_A = 8'h7E;
   localparam logic [7:0] PAYLOAD_LO_B = 8'hA1;
   localparam logic [7:0] PAYLOAD_HI_B = 8'hFE;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      HEAD     = 3'd1,
      PAYLOAD  = 3'd2,
      TAIL     = 3'd3,
      WAIT_DIG = 3'd4,
      DONE     = 3'd5
   } lh_state_e;

   function automatic logic is_payload_byte(input logic [7:0] b);
      return ((b >= PAYLOAD_LO_A) && (b <= PAYLOAD_HI_A)) ||
             ((b >= PAYLOAD_LO_B) && (b <= PAYLOAD_HI_B));
   endfunction

endpackage

// File: rtl/lh_byte_fifo.sv
// Single-clock byte FIFO with first-word fall-through read data and a
// synchronous flush. Pointers wrap modulo DEPTH (power of two).
module lh_byte_fifo #(
   parameter int DEPTH = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [7:0] wdata,
   input  logic       pop,
   input  logic       flush,
   output logic [7:0] rdata,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign rdata   = mem[rd_ptr];

   // Storage array; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointer and occupancy tracking; reset and flush both empty the FIFO.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/lh_message_feeder.sv
// Buffers payload bytes, then frames them as HEAD, payload..., TAIL towards a
// hash core, each byte held HOLD cycles, and collects the resulting digest.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | accepting payload writes, waiting for start
// HEAD     | driving HEAD_BYTE for HOLD cycles
// PAYLOAD  | driving one popped FIFO byte per HOLD cycles
// TAIL     | driving TAIL_BYTE for HOLD cycles; an early digest is taken
// WAIT_DIG | waiting up to TIMEOUT cycles for digest_ready
// DONE     | single-cycle result_valid pulse, then back to IDLE
module lh_message_feeder
   import lh_pkg::*;
#(
   parameter int DEPTH   = 32,
   parameter int HOLD    = 2,
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  msg_wdata,
   input  logic        msg_wvalid,
   output logic        msg_wready,
   input  logic        start,
   output logic        busy,
   output logic [7:0]  message_byte,
   output logic        message_valid,
   input  logic [63:0] digest,
   input  logic        digest_ready,
   input  logic        err_invalid_message_byte,
   output logic [63:0] result_digest,
   output logic        result_valid,
   output logic        result_err,
   output logic        wr_err
);

   localparam int HW = $clog2(HOLD + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD - 1);
   localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT - 1);

   lh_state_e     state;
   logic [HW-1:0] hold_cnt;
   logic [TW-1:0] to_cnt;
   logic [7:0]    cur_byte;

   logic       framing;
   logic       hold_done;
   logic       abort;
   logic       wr_accept;
   logic       fifo_push;
   logic       fifo_pop;
   logic       fifo_full;
   logic       fifo_empty;
   logic [7:0] fifo_rdata;

   assign busy       = (state != IDLE);
   assign msg_wready = !busy && !fifo_full;
   assign wr_accept  = msg_wvalid && msg_wready;
   assign fifo_push  = wr_accept && is_payload_byte(msg_wdata);

   assign framing    = (state == HEAD) || (state == PAYLOAD) || (state == TAIL);
   assign hold_done  = (hold_cnt == '0);
   assign abort      = framing && err_invalid_message_byte;
   // The next payload byte is taken at the end of the current byte's hold.
   assign fifo_pop   = ((state == HEAD) || (state == PAYLOAD)) &&
                       !err_invalid_message_byte && hold_done && !fifo_empty;

   assign message_valid = framing && (hold_cnt == HOLD_LOAD);
   assign result_valid  = (state == DONE);

   lh_byte_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .wdata (msg_wdata),
      .pop   (fifo_pop),
      .flush (abort),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Byte presented to the hash core; quiet zero whenever not framing.
   always_comb begin
      message_byte = 8'h00;
      case (state)
         HEAD:    message_byte = HEAD_BYTE;
         PAYLOAD: message_byte = cur_byte;
         TAIL:    message_byte = TAIL_BYTE;
         default: message_byte = 8'h00;
      endcase
   end

   // Sticky flag for payload writes that were accepted but dropped as illegal.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_err <= 1'b0;
      end else if (wr_accept && !is_payload_byte(msg_wdata)) begin
         wr_err <= 1'b1;
      end
   end

   // Framing FSM with hold and timeout down-counters and result capture.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         hold_cnt      <= '0;
         to_cnt        <= '0;
         cur_byte      <= 8'h00;
         result_digest <= 64'h0;
         result_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= HEAD;
                  hold_cnt <= HOLD_LOAD;
               end
            end
            HEAD, PAYLOAD: begin
               if (abort) begin
                  state         <= DONE;
                  result_digest <= 64'h0;
                  result_err    <= 1'b1;
               end else if (hold_done) begin
                  hold_cnt <= HOLD_LOAD;
                  if (fifo_empty) begin
                     state <= TAIL;
                  end else begin
                     state    <= PAYLOAD;
                     cur_byte <= fifo_rdata;
                  end
               end else begin
                  hold_cnt <= hold_cnt - HW'(1);
               end
            end
            TAIL: begin
               if (abort) begin
                  state         <= DONE;
                  result_digest <= 64'h0;
                  result_err    <= 1'b1;
               end else if (digest_ready) begin
                  // Fast cores may answer before the tail hold has finished.
                  state         <= DONE;
                  result_digest <= digest;
                  result_err    <= 1'b0;
               end else if (hold_done) begin
                  state  <= WAIT_DIG;
                  to_cnt <= TO_LOAD;
               end else begin
                  hold_cnt <= hold_cnt - HW'(1);
               end
            end
            WAIT_DIG: begin
               if (digest_ready) begin
                  state         <= DONE;
                  result_digest <= digest;
                  result_err    <= 1'b0;
               end else if (to_cnt == '0) begin
                  state         <= DONE;
                  result_digest <= 64'h0;
                  result_err    <= 1'b1;
               end else begin
                  to_cnt <= to_cnt - TW'(1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
